// File: rtl/stall_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stall_mem_pkg                                                        |
// | Shared state type, default parameters and sizing helper for stall_mem|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package stall_mem_pkg;

    localparam int c_DATA_W_DEF  = 16;
    localparam int c_ADDR_W_DEF  = 16;
    localparam int c_DEPTH_DEF   = 1024;
    localparam int c_LATENCY_DEF = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Smallest width able to hold LATENCY-1; a zero-width counter is not legal.
    function automatic int cntWidth(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stall_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stall_mem_array                                                      |
// | DEPTH x DATA_W storage, synchronous write, combinational read        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stall_mem_array
    import stall_mem_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int DEPTH  = c_DEPTH_DEF,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wrData,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_idx] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/stall_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stall_mem                                                            |
// | Fixed-latency word memory with stall/done handshake, misalign flag   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stall_mem
    import stall_mem_pkg::*;
#(
    parameter int DATA_W  = c_DATA_W_DEF,
    parameter int ADDR_W  = c_ADDR_W_DEF,
    parameter int DEPTH   = c_DEPTH_DEF,
    parameter int LATENCY = c_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int              CNT_W      = cntWidth(LATENCY);
    localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_odd;
    logic [DATA_W-1:0] r_data;
    logic              r_wr;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_dataOut;

    logic              w_req;
    logic              w_complete;
    logic              w_memWr;
    logic [IDX_W-1:0]  w_inIdx;
    logic [DATA_W-1:0] w_rdData;

    assign w_req      = wr | rd;
    // Word index is the half-word address folded onto the array size.
    assign w_inIdx    = IDX_W'(addr >> 1);
    assign w_complete = (r_state == BUSY) && (r_cnt == '0);
    assign w_memWr    = w_complete & r_wr & ~r_odd;

    stall_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk      (clk),
        .i_wrEn   (w_memWr),
        .i_idx    (r_idx),
        .i_wrData (r_data),
        .o_rdData (w_rdData)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_odd     <= 1'b0;
            r_data    <= '0;
            r_wr      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_dataOut <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A request still high in the done cycle is the one retiring.
                    if (w_req && !r_done) begin
                        r_idx   <= w_inIdx;
                        r_odd   <= addr[0];
                        r_data  <= data_in;
                        r_wr    <= wr;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_done  <= 1'b1;
                        r_err   <= r_odd;
                        r_state <= IDLE;
                        if (!r_wr && !r_odd) begin
                            r_dataOut <= w_rdData;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall    = (r_state == BUSY) | ((r_state == IDLE) & w_req & ~r_done);
    assign done     = r_done;
    assign err      = r_err;
    assign data_out = r_dataOut;

endmodule
`default_nettype wire

// File: tb/tb_stall_mem.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_stall_mem                                                         |
// | Directed and random checks of stall_mem against a transaction model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_stall_mem;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataIn;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] dataOut;
    logic              stall;
    logic              done;
    logic              err;

    logic              rst1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] dataIn1;
    logic              wr1;
    logic              rd1;
    logic [DATA_W-1:0] dataOut1;
    logic              stall1;
    logic              done1;
    logic              err1;

    always #5 clk = ~clk;

    stall_mem #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (DEPTH), .LATENCY (LATENCY)
    ) dut (
        .clk (clk), .rst (rst), .addr (addr), .data_in (dataIn), .wr (wr), .rd (rd),
        .data_out (dataOut), .stall (stall), .done (done), .err (err)
    );

    stall_mem #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .DEPTH (16), .LATENCY (1)
    ) dut1 (
        .clk (clk), .rst (rst1), .addr (addr1), .data_in (dataIn1), .wr (wr1), .rd (rd1),
        .data_out (dataOut1), .stall (stall1), .done (done1), .err (err1)
    );

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] modelMem [int];
    logic [DATA_W-1:0] modelOut;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access: present, hold (scrambling the ignored inputs), check the done cycle.
    task automatic doAccess(input bit waitFirst, input bit w, input bit r,
                            input logic [15:0] a, input logic [15:0] d);
        int n;
        int idx;
        if (waitFirst) @(negedge clk);
        checkVal("idle_done", done, 0);
        checkVal("idle_err", err, 0);
        wr = w; rd = r; addr = a; dataIn = d;
        #1 checkVal("stall_req", stall, 1);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (done || n > LATENCY + 4) break;
            checkVal("stall_busy", stall, 1);
            addr   = 16'($urandom);
            dataIn = 16'($urandom);
            {wr, rd} = 2'($urandom_range(1, 3));
        end
        idx = (int'(a) / 2) % DEPTH;
        if (!a[0]) begin
            if (w) modelMem[idx] = d;
            else if (modelMem.exists(idx)) modelOut = modelMem[idx];
        end
        checkVal("done_latency", n, LATENCY + 1);
        checkVal("done_err", err, {31'b0, a[0]});
        checkVal("data_out", dataOut, modelOut);
        checkVal("stall_done", stall, 0);
        wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        bit          w;
        int          idx;
        bit          expDone;
        int          acceptEdge;

        rst = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; dataIn = '0;
        rst1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; addr1 = '0; dataIn1 = '0;
        modelOut = '0;
        repeat (3) @(negedge clk);
        checkVal("rst_data_out", dataOut, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_err", err, 0);
        checkVal("rst_stall", stall, 0);

        // Request presented together with reset release is taken on the first edge.
        rst = 1'b1;
        doAccess(0, 1, 0, 16'h0010, 16'hBEEF);
        doAccess(1, 0, 1, 16'h0010, 16'h0000);
        doAccess(1, 0, 1, 16'h0011, 16'h0000);
        doAccess(1, 0, 1, 16'h0010, 16'h0000);
        doAccess(1, 1, 1, 16'h0020, 16'h1234);
        doAccess(1, 0, 1, 16'h0020, 16'h0000);
        doAccess(1, 1, 0, 16'h0800, 16'h5A5A);
        doAccess(1, 0, 1, 16'h0000, 16'h0000);

        // Reset in the middle of a write must abort it.
        doAccess(1, 1, 0, 16'h0040, 16'h0001);
        @(negedge clk);
        wr = 1'b1; addr = 16'h0040; dataIn = 16'hFFFF;
        repeat (2) @(negedge clk);
        rst = 1'b0; wr = 1'b0;
        #1;
        checkVal("midrst_done", done, 0);
        checkVal("midrst_err", err, 0);
        checkVal("midrst_data_out", dataOut, 0);
        checkVal("midrst_stall", stall, 0);
        modelOut = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < LATENCY + 2; i++) begin
            @(negedge clk);
            checkVal("midrst_nodone", done, 0);
        end
        doAccess(1, 0, 1, 16'h0040, 16'h0000);
        checkVal("abort_kept", dataOut, 16'h0001);

        for (int i = 0; i < 40; i++) begin
            a   = 16'($urandom);
            w   = 1'($urandom_range(0, 1));
            idx = (int'(a) / 2) % DEPTH;
            if (!w && !a[0] && !modelMem.exists(idx)) w = 1'b1;
            doAccess(1, w, !w || ($urandom_range(0, 1) == 1), a, 16'($urandom));
        end

        // LATENCY=1 instance with rd held high: the request is re-accepted two
        // edges after each completion, so stall drops only in done cycles.
        @(negedge clk);
        rst1 = 1'b1; rd1 = 1'b1; addr1 = 16'h0033;
        acceptEdge = 1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            expDone = (n == acceptEdge + 1);
            if (expDone) acceptEdge = n + 2;
            checkVal("l1_done", done1, {31'b0, expDone});
            checkVal("l1_stall", stall1, {31'b0, !expDone});
            checkVal("l1_err", err1, {31'b0, expDone});
        end
        checkVal("l1_data_out", dataOut1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
